led_pwm4: RTL
=============

LED_PWM4 -- requirements
Module: led_pwm4

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the duty value and of the PWM phase counter.
REQ-002 SHALL have parameter PRESCALE, default 16: CLK cycles per PWM phase step, range 1..65535.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESETN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port I  input  WIDTH  duty value from the upstream counter output O.
REQ-006 SHALL have port LOAD  input  1  strobe that captures I into the pending duty register, sampled on CLK.
REQ-007 SHALL have port O  output  1  registered PWM output driving the LED.
REQ-008 SHALL have port TICK  output  1  one-cycle pulse at each PWM period wrap.
REQ-009 SHALL have port DUTY  output  WIDTH  the duty value currently in effect.

Function
REQ-010 SHALL count a prescaler 0..PRESCALE-1 and assert an internal step on the cycle it equals PRESCALE-1, then wrap it to 0; PRESCALE=1 SHALL step every cycle.
REQ-011 SHALL advance phase (WIDTH bits) by 1 on each step, wrapping 2^WIDTH-1 -> 0.
REQ-012 SHALL define wrap as step AND phase==2^WIDTH-1, and SHALL register TICK=1 on the cycle after wrap, for exactly one cycle.
REQ-013 SHALL, on LOAD=1, load pend<=I and set pend_valid; with multiple LOADs before a wrap, the last one wins.
REQ-014 SHALL, on wrap, load active<=pend and clear pend_valid if pend_valid=1; otherwise active is held.
REQ-015 SHALL, when LOAD and wrap occur in the same cycle, load active directly from I (bypass) and leave pend_valid clear.
REQ-016 SHALL register O<=(phase_next < active_next) unsigned, so O changes one cycle after the phase/active update that causes it.
REQ-017 SHALL give duty 0 O constantly 0, and duty d high for d of every 2^WIDTH steps; full-on is not reachable (maximum 15/16 at WIDTH=4).
REQ-018 SHALL change active only at wrap, so no PWM period is truncated or glitched.
REQ-019 SHALL drive DUTY=active directly.

Reset
REQ-020 SHALL, while RESETN=0, force prescaler, phase, pend, pend_valid, active, O, TICK and DUTY to 0 immediately, without waiting for CLK.
REQ-021 SHALL, on reset mid-period, discard the pending duty, and the first wrap after release SHALL occur PRESCALE*2^WIDTH cycles after the first active edge.

Configuration
REQ-022 SHALL, when LED_PWM4_GAMMA_EN is defined, load active with gamma(x) instead of x per REQ-014/015; table for x=0..15 is 0,0,0,1,1,2,2,3,4,5,6,7,9,11,13,15.
REQ-023 SHALL, with LED_PWM4_GAMMA_EN defined and WIDTH!=4, fail elaboration.
REQ-024 SHALL, without LED_PWM4_GAMMA_EN, use the linear mapping active=x, and the gamma table logic SHALL be absent.
REQ-025 SHALL have DUTY report the post-mapping value in both builds.

Structure
REQ-026 SHALL place the WIDTH default, the PRESCALE default and the gamma table function in package led_pwm4_pkg.
REQ-027 SHALL implement the prescaler as sub-module led_pwm4_prescale (ports CLK, RESETN, STEP), parameterised by PRESCALE.

Verification
REQ-028 Reset-release scenario (PRESCALE=1, no LOAD): O=0 always; TICK pulses every 16 cycles; DUTY=0.
REQ-029 Linear-duty scenario (PRESCALE=1, LOAD I=4 once): DUTY becomes 4 after the next wrap; thereafter O is high exactly 4 of every 16 cycles, and phase 15 -> 0 gives no glitch.
REQ-030 Last-wins scenario: LOAD I=3 then LOAD I=9 in the same period -> DUTY goes 0 -> 9 at wrap, and 3 is never applied.
REQ-031 Simultaneous scenario: LOAD I=15 on the wrap cycle -> DUTY=15 on the next cycle; O high 15 of every 16 cycles; pend_valid stays 0.
REQ-032 Asynchronous-reset scenario (PRESCALE=16): RESETN low mid-period with DUTY=7 -> O, TICK and DUTY are 0 before the next CLK edge; the first TICK after release is at 256 cycles.
REQ-033 Gamma-build scenario: LOAD I=12 -> DUTY=9 after wrap; LOAD I=2 -> DUTY=0 and O stays low.

Source files
------------

// File: rtl/led_pwm4_pkg.sv
// Shared defaults and the perceptual (gamma) duty table for the LED PWM block.
// The table is only referenced when LED_PWM4_GAMMA_EN is defined.
package led_pwm4_pkg;

  localparam int LED_PWM4_WIDTH    = 4;
  localparam int LED_PWM4_PRESCALE = 16;

  // Roughly square-law brightness curve for a 4-bit duty
  localparam logic [3:0] GAMMA_LUT [16] = '{
    4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15
  };

  function automatic logic [3:0] led_pwm4_gamma(input logic [3:0] x);
    return GAMMA_LUT[x];
  endfunction

endpackage

// File: rtl/led_pwm4_prescale.sv
// Free-running prescaler: STEP is high for one CLK cycle out of every PRESCALE.
// With PRESCALE=1 the counter is pinned at 0 and STEP is permanently high.
module led_pwm4_prescale
  import led_pwm4_pkg::*;
#(
  parameter int PRESCALE = LED_PWM4_PRESCALE
) (
  input  logic CLK,
  input  logic RESETN,
  output logic STEP
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("led_pwm4_prescale: PRESCALE must be in 1..65535");
  end

  logic [CW-1:0] cnt;

  assign STEP = (cnt == LAST);

  // Count 0..PRESCALE-1, wrapping on the step cycle
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)   cnt <= '0;
    else if (STEP) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/led_pwm4.sv
// LED PWM driver with double-buffered duty. A new duty is staged by LOAD and
// only takes effect at the period wrap, so no period is ever truncated.
// Optional build macro: LED_PWM4_GAMMA_EN maps duty through a gamma table
// (WIDTH must be 4 in that build).
module led_pwm4
  import led_pwm4_pkg::*;
#(
  parameter int WIDTH    = LED_PWM4_WIDTH,
  parameter int PRESCALE = LED_PWM4_PRESCALE
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             LOAD,
  output logic             O,
  output logic             TICK,
  output logic [WIDTH-1:0] DUTY
);

  localparam logic [WIDTH-1:0] PH_MAX = '1;

  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] phase, phase_next;
  logic [WIDTH-1:0] pend;
  logic             pend_valid;
  logic [WIDTH-1:0] active, active_next;
  logic [WIDTH-1:0] map_i, map_pend;

  led_pwm4_prescale #(.PRESCALE(PRESCALE)) u_prescale (
    .CLK    (CLK),
    .RESETN (RESETN),
    .STEP   (step)
  );

`ifdef LED_PWM4_GAMMA_EN
  if (WIDTH != 4) begin : g_bad_width
    $error("led_pwm4: gamma mapping requires WIDTH == 4");
  end
  assign map_i    = led_pwm4_gamma(I);
  assign map_pend = led_pwm4_gamma(pend);
`else
  assign map_i    = I;
  assign map_pend = pend;
`endif

  assign wrap       = step && (phase == PH_MAX);
  assign phase_next = step ? phase + 1'b1 : phase;
  assign DUTY       = active;

  // Duty swap at wrap; a LOAD coinciding with wrap bypasses the pending slot
  always_comb begin
    active_next = active;
    if (wrap) begin
      if (LOAD)            active_next = map_i;
      else if (pend_valid) active_next = map_pend;
    end
  end

  // Phase, duty buffers and registered outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      phase      <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      active     <= '0;
      O          <= 1'b0;
      TICK       <= 1'b0;
    end else begin
      phase  <= phase_next;
      active <= active_next;
      O      <= (phase_next < active_next);
      TICK   <= wrap;
      if (LOAD) pend <= I;
      if (wrap)      pend_valid <= 1'b0;
      else if (LOAD) pend_valid <= 1'b1;
    end
  end

endmodule
